// File: rtl/vga_frame_fetch.sv
// -----------------------------------------------------------------------------
// vga_frame_fetch
//   Display-side fetch stage between the VGA timing generator and a column-major
//   frame buffer. The source image is upscaled SCALE x SCALE into a window that
//   starts at (H_OFFSET, V_OFFSET). One read address is produced per pixel using
//   incremental counters, so no multiplier is needed. The in-window flag is
//   delayed to line up with the RAM read latency and gates the registered RGB.
//
// Ports
//   clk_vga         in   1       pixel clock, sole clock
//   reset           in   1       synchronous, active-high
//   x_loc           in   11      current column, +1 per clock within a line
//   y_loc           in   11      current line
//   bram_read_addr  out  ADDR_W  frame-buffer read address (src_y + src_x*IMG_H)
//   bram_read_data  in   12      frame-buffer data {R[3:0],G[3:0],B[3:0]}
//   RED_out         out  4       registered red
//   GREEN_out       out  4       registered green
//   BLUE_out        out  4       registered blue
//   frame_start     out  1       one-cycle pulse after (x_loc,y_loc)==(0,0)
// -----------------------------------------------------------------------------
module vga_frame_fetch #(
  parameter int H_RES       = 1280,
  parameter int V_RES       = 1024,
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE       = 4,
  parameter int H_OFFSET    = 0,
  parameter int V_OFFSET    = 32,
  parameter int RAM_LATENCY = 2,
  parameter int ADDR_W      = 18
) (
  input  logic              clk_vga,
  input  logic              reset,
  input  logic [10:0]       x_loc,
  input  logic [10:0]       y_loc,
  output logic [ADDR_W-1:0] bram_read_addr,
  input  logic [11:0]       bram_read_data,
  output logic [3:0]        RED_out,
  output logic [3:0]        GREEN_out,
  output logic [3:0]        BLUE_out,
  output logic              frame_start
);

  localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int SRC_Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [10:0] H_FIRST = 11'(H_OFFSET);
  localparam logic [10:0] H_SPAN  = 11'(IMG_W * SCALE - 1);
  localparam logic [10:0] H_LAST  = 11'(H_OFFSET + IMG_W * SCALE - 1);
  localparam logic [10:0] V_FIRST = 11'(V_OFFSET);
  localparam logic [10:0] V_SPAN  = 11'(IMG_H * SCALE - 1);

  localparam logic [SUB_W-1:0]   SUB_MAX   = SUB_W'(SCALE - 1);
  localparam logic [SRC_Y_W-1:0] SRC_Y_MAX = SRC_Y_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0]  COL_STEP  = ADDR_W'(IMG_H);
  localparam logic [ADDR_W-1:0]  ADDR_MAX  = ADDR_W'(IMG_W * IMG_H - 1);

  // Window decode. Offsetting by the window start lets an unsigned wrap-around
  // turn "below the start" into "far above the span", so each axis needs only
  // one comparison.
  logic [10:0] x_rel;
  logic [10:0] y_rel;
  logic        h_in;
  logic        v_in;
  logic        in_win;
  logic        line_end;

  assign x_rel    = x_loc - H_FIRST;
  assign y_rel    = y_loc - V_FIRST;
  assign h_in     = (x_rel <= H_SPAN);
  assign v_in     = (y_rel <= V_SPAN);
  assign in_win   = h_in && v_in;
  assign line_end = in_win && (x_loc == H_LAST);

  // Scan counters
  logic [SUB_W-1:0]   x_sub;
  logic [SUB_W-1:0]   y_sub;
  logic [ADDR_W-1:0]  col_base;
  logic [SRC_Y_W-1:0] src_y;

  // Address generation
  logic [ADDR_W:0]    addr_sum;
  logic [ADDR_W-1:0]  addr_next;

  assign addr_sum = {1'b0, col_base} + (ADDR_W + 1)'(src_y);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    addr_next = '0;
    if (in_win) begin
      if (addr_sum > {1'b0, ADDR_MAX}) begin
        addr_next = ADDR_MAX;
      end else begin
        addr_next = addr_sum[ADDR_W-1:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      x_sub    <= '0;
      col_base <= '0;
      y_sub    <= '0;
      src_y    <= '0;
    end else begin
      // Horizontal: cleared in blanking, so each line's window starts at column 0.
      if (!in_win) begin
        x_sub    <= '0;
        col_base <= '0;
      end else if (x_sub == SUB_MAX) begin
        x_sub    <= '0;
        col_base <= col_base + COL_STEP;
      end else begin
        x_sub <= x_sub + 1'b1;
      end

      // Vertical: advances once per line on the last window pixel.
      if (!v_in) begin
        y_sub <= '0;
        src_y <= '0;
      end else if (line_end) begin
        if (y_sub == SUB_MAX) begin
          y_sub <= '0;
          src_y <= (src_y == SRC_Y_MAX) ? '0 : src_y + 1'b1;
        end else begin
          y_sub <= y_sub + 1'b1;
        end
      end
    end
  end

  // Stage 0 lines up with the address register; stage RAM_LATENCY lines up
  // with valid read data.
  logic [RAM_LATENCY:0] win_pipe;

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      // NOTE: the flag delay line is cleared on reset so a stale in-window flag
      // cannot release RGB before a fresh one has propagated.
      win_pipe       <= '0;
      bram_read_addr <= '0;
      RED_out        <= '0;
      GREEN_out      <= '0;
      BLUE_out       <= '0;
      frame_start    <= 1'b0;
    end else begin
      win_pipe       <= {win_pipe[RAM_LATENCY-1:0], in_win};
      bram_read_addr <= addr_next;
      frame_start    <= (x_loc == 11'd0) && (y_loc == 11'd0);
      if (win_pipe[RAM_LATENCY]) begin
        RED_out   <= bram_read_data[11:8];
        GREEN_out <= bram_read_data[7:4];
        BLUE_out  <= bram_read_data[3:0];
      end else begin
        RED_out   <= '0;
        GREEN_out <= '0;
        BLUE_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_fetch.sv
// -----------------------------------------------------------------------------
// tb_vga_frame_fetch
//   Drives two instances from one pixel stream: the default geometry
//   (SCALE=4, RAM_LATENCY=2, V_OFFSET=32) and a SCALE=1, RAM_LATENCY=1,
//   V_OFFSET=0 variant. Each has a RAM model returning addr[11:0]. A
//   multiplier-based reference computes expected address/RGB/frame_start per
//   driven pixel; these are queued with their due cycle and compared when the
//   DUT produces them. Lines that are not of interest are shortened to the
//   pixels that step the vertical counters, and are not compared.
// -----------------------------------------------------------------------------
module tb_vga_frame_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x_loc;
  logic [10:0] y_loc;

  logic [17:0] addr1, addr2;
  logic [11:0] data1, data2;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        fs1, fs2;

  always #5 clk = ~clk;

  vga_frame_fetch dut (
    .clk_vga(clk), .reset(reset), .x_loc(x_loc), .y_loc(y_loc),
    .bram_read_addr(addr1), .bram_read_data(data1),
    .RED_out(r1), .GREEN_out(g1), .BLUE_out(b1), .frame_start(fs1)
  );

  vga_frame_fetch #(.SCALE(1), .RAM_LATENCY(1), .V_OFFSET(0)) dut_s1 (
    .clk_vga(clk), .reset(reset), .x_loc(x_loc), .y_loc(y_loc),
    .bram_read_addr(addr2), .bram_read_data(data2),
    .RED_out(r2), .GREEN_out(g2), .BLUE_out(b2), .frame_start(fs2)
  );

  // RAM models: data = addr[11:0], latency 2 and 1 edges respectively.
  logic [17:0] ram1_a;
  logic [11:0] ram1_b;
  logic [11:0] ram2_a;
  always @(posedge clk) begin
    ram1_a <= addr1;
    ram1_b <= ram1_a[11:0];
    ram2_a <= addr2[11:0];
  end
  assign data1 = ram1_b;
  assign data2 = ram2_a;

  typedef struct {
    int          due;
    bit          chk;
    int          x;
    int          y;
    logic [17:0] addr;
    logic [11:0] rgb;
    bit          fs;
  } exp_t;

  exp_t aq1[$], rq1[$], aq2[$], rq2[$];

  int cyc      = 0;
  int n_checks = 0;
  int n_fail   = 0;
  bit full_line = 1'b0;
  bit exact1    = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int x, input int y, input int s, input int vo, input bit chk);
    exp_t e;
    bit   win;
    int   a;
    win    = (x < 320 * s) && (y >= vo) && (y < vo + 240 * s);
    a      = win ? (x / s) * 240 + (y - vo) / s : 0;
    e.due  = 0;
    e.chk  = chk;
    e.x    = x;
    e.y    = y;
    e.addr = 18'(a);
    e.rgb  = win ? 12'(a) : 12'h000;
    e.fs   = (x == 0) && (y == 0);
    return e;
  endfunction

  // Applies one pixel on the falling edge; it is sampled on the next rising edge.
  task automatic drive(input int x, input int y);
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    x_loc = 11'(x);
    y_loc = 11'(y);
    e = model(x, y, 4, 32, full_line && exact1);
    e.due = cyc + 1; aq1.push_back(e);
    e.due = cyc + 4; rq1.push_back(e);
    e = model(x, y, 1, 0, full_line);
    e.due = cyc + 1; aq2.push_back(e);
    e.due = cyc + 3; rq2.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " addr1"}, 32'(addr1), 32'd0);
    check({tag, " rgb1"},  32'({r1, g1, b1}), 32'd0);
    check({tag, " fs1"},   32'(fs1), 32'd0);
    check({tag, " addr2"}, 32'(addr2), 32'd0);
    check({tag, " rgb2"},  32'({r2, g2, b2}), 32'd0);
    check({tag, " fs2"},   32'(fs2), 32'd0);
  endtask

  task automatic pulse_reset(input int x, input int y);
    @(negedge clk);
    reset = 1'b1;
    x_loc = 11'(x);
    y_loc = 11'(y);
    aq1.delete(); rq1.delete(); aq2.delete(); rq2.delete();
    @(posedge clk);
    #1;
    check_zero("mid_reset");
  endtask

  // Full lines scan every column; short lines only hit the last window pixel
  // of each instance (x=319 and x=1279) and one blank pixel.
  task automatic run_line(input int y, input bit full);
    full_line = full;
    if (full) begin
      for (int x = 0; x < 1284; x++) drive(x, y);
    end else begin
      drive(319, y);
      drive(1279, y);
      drive(1280, y);
    end
  endtask

  // Scoreboard: pop entries that fall due on this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (aq1.size() != 0 && aq1[0].due == cyc) begin
        e = aq1.pop_front();
        if (e.chk) check($sformatf("addr1@%0d,%0d", e.x, e.y), 32'(addr1), 32'(e.addr));
        check($sformatf("fs1@%0d,%0d", e.x, e.y), 32'(fs1), 32'(e.fs));
      end
      while (rq1.size() != 0 && rq1[0].due == cyc) begin
        e = rq1.pop_front();
        if (e.chk) check($sformatf("rgb1@%0d,%0d", e.x, e.y), 32'({r1, g1, b1}), 32'(e.rgb));
      end
      while (aq2.size() != 0 && aq2[0].due == cyc) begin
        e = aq2.pop_front();
        if (e.chk) check($sformatf("addr2@%0d,%0d", e.x, e.y), 32'(addr2), 32'(e.addr));
        check($sformatf("fs2@%0d,%0d", e.x, e.y), 32'(fs2), 32'(e.fs));
      end
      while (rq2.size() != 0 && rq2[0].due == cyc) begin
        e = rq2.pop_front();
        if (e.chk) check($sformatf("rgb2@%0d,%0d", e.x, e.y), 32'({r2, g2, b2}), 32'(e.rgb));
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b1;
    x_loc = '0;
    y_loc = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

    // Frame A: window edges, sub-pixel wrap, blank lines either side of the
    // window, and the last source pixel of both instances.
    exact1 = 1'b1;
    for (int y = 0; y < 1024; y++) begin
      run_line(y, (y == 0) || (y == 31) || (y == 32) || (y == 33) || (y == 35) ||
                  (y == 36) || (y == 239) || (y == 240) || (y == 991) || (y == 992));
    end

    // Frame B: reset in the middle of window line 500. The default instance
    // is only compared again from the next frame; the SCALE=1 instance is
    // outside its window there and stays exact.
    run_line(0, 1'b1);
    for (int y = 1; y < 500; y++) run_line(y, 1'b0);
    full_line = 1'b1;
    for (int x = 0; x < 600; x++) drive(x, 500);
    pulse_reset(600, 500);
    exact1 = 1'b0;
    for (int x = 601; x < 1284; x++) drive(x, 500);
    for (int y = 501; y < 1024; y++) run_line(y, 1'b0);

    // Frame C: exact again after the mid-frame reset.
    exact1 = 1'b1;
    for (int y = 0; y < 1024; y++) begin
      run_line(y, (y == 0) || (y == 32) || (y == 36) || (y == 991) || (y == 992));
    end

    // Drain the scoreboard with blank pixels, bounded.
    full_line = 1'b1;
    wait_cycles = 0;
    while ((aq1.size() + rq1.size() + aq2.size() + rq2.size()) != 0 && wait_cycles < 20) begin
      drive(1300, 1000);
      wait_cycles++;
    end
    repeat (6) @(posedge clk);
    #2;
    check("drain", 32'(aq1.size() + rq1.size() + aq2.size() + rq2.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
